// File: rtl/ball_mover_pkg.sv
// Shared play-field geometry and ball FSM encoding.
// Imported by the ball mover and its bounce logic.
`ifndef PLATY
`define PLATY 224
`endif

package ball_mover_pkg;

  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int PLATY     = `PLATY;
  localparam int PADDLE_W  = 32;
  localparam int BALL_SIZE = 4;

  localparam logic [9:0] X_MAX    = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0] PARK_OFS = 10'(PADDLE_W/2 - BALL_SIZE/2);
  localparam logic [9:0] PARK_Y   = 10'(PLATY - BALL_SIZE);
  localparam logic [9:0] FLOOR_Y  = 10'(SCREEN_H - BALL_SIZE);

  typedef enum logic [1:0] {
    PARKED = 2'd0,
    MOVE   = 2'd1,
    FALL   = 2'd2
  } state_t;

  function automatic logic [10:0] w11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/ball_mover_if.sv
// Ball mover control inputs and ball state outputs.
// master drives paddle/strobes, slave reports the ball.
interface ball_mover_if;
  logic       tick;
  logic       launch;
  logic [9:0] paddle_x;
  logic       brick_flip_x;
  logic       brick_flip_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_right;
  logic       dir_down;
  logic       in_play;
  logic       respawn;

  modport master (
    output tick, launch, paddle_x,
    output brick_flip_x, brick_flip_y,
    input  ball_x, ball_y, dir_right,
    input  dir_down, in_play, respawn
  );

  modport slave (
    input  tick, launch, paddle_x,
    input  brick_flip_x, brick_flip_y,
    output ball_x, ball_y, dir_right,
    output dir_down, in_play, respawn
  );
endinterface

// File: rtl/ball_bounce_logic.sv
// Combinational wall/paddle/brick flip and miss decisions.
// All inputs are the pre-move ball state.
module ball_bounce_logic
  import ball_mover_pkg::*;
(
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic [9:0] i_paddle_x,
  input  logic       i_dir_right,
  input  logic       i_dir_down,
  input  logic       i_play,
  input  logic       i_flip_x,
  input  logic       i_flip_y,
  output logic       o_fx,
  output logic       o_fy,
  output logic       o_miss
);

  logic [10:0] w_x, w_y, w_px;
  logic        w_r_wall, w_l_wall, w_top;
  logic        w_line, w_over;

  // 11-bit sums so edge tests never wrap
  always_comb begin
    w_x  = w11(i_x);
    w_y  = w11(i_y);
    w_px = w11(i_paddle_x);
    w_r_wall = i_dir_right &&
      (w_x + 11'(BALL_SIZE) >= 11'(SCREEN_W));
    w_l_wall = !i_dir_right && (i_x == 10'd0);
    w_top    = !i_dir_down && (i_y == 10'd0);
    w_line   = i_dir_down &&
      (w_y + 11'(BALL_SIZE) == 11'(PLATY));
    w_over   = (w_x + 11'(BALL_SIZE) > w_px) &&
      (w_x < w_px + 11'(PADDLE_W));
    o_fx   = w_r_wall | w_l_wall |
      (i_play & i_flip_x);
    o_fy   = w_top |
      (i_play & (i_flip_y | (w_line & w_over)));
    o_miss = i_play & w_line & ~w_over;
  end

endmodule

// File: rtl/ball_mover.sv
// Ball FSM: park on paddle, launch, move, bounce,
// fall past the paddle line and re-park.
module ball_mover
  import ball_mover_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  ball_mover_if.slave  bus
);

  state_t     r_state;
  logic [9:0] r_x, r_y;
  logic       r_dr, r_dd;
  logic       r_in_play, r_respawn;
  logic       r_bfx, r_bfy;

  logic       w_fx, w_fy, w_miss;
  logic       w_play, w_dr, w_dd;
  logic       w_flip_x, w_flip_y;
  logic [9:0] w_nx, w_ny, w_y_inc, w_park_x;

  assign bus.ball_x    = r_x;
  assign bus.ball_y    = r_y;
  assign bus.dir_right = r_dr;
  assign bus.dir_down  = r_dd;
  assign bus.in_play   = r_in_play;
  assign bus.respawn   = r_respawn;

  ball_bounce_logic u_bounce (
    .i_x         (r_x),
    .i_y         (r_y),
    .i_paddle_x  (bus.paddle_x),
    .i_dir_right (r_dr),
    .i_dir_down  (r_dd),
    .i_play      (w_play),
    .i_flip_x    (w_flip_x),
    .i_flip_y    (w_flip_y),
    .o_fx        (w_fx),
    .o_fy        (w_fy),
    .o_miss      (w_miss)
  );

  // new direction first, then one clamped pixel step
  always_comb begin
    w_play   = (r_state == MOVE);
    w_flip_x = r_bfx | bus.brick_flip_x;
    w_flip_y = r_bfy | bus.brick_flip_y;
    w_dr     = r_dr ^ w_fx;
    w_dd     = r_dd ^ w_fy;
    w_y_inc  = r_y + 10'd1;
    w_park_x = bus.paddle_x + PARK_OFS;
    if (w_dr)
      w_nx = (r_x >= X_MAX) ? X_MAX : r_x + 10'd1;
    else
      w_nx = (r_x == 10'd0) ? 10'd0 : r_x - 10'd1;
    if (w_dd)
      w_ny = w_y_inc;
    else
      w_ny = (r_y == 10'd0) ? 10'd0 : r_y - 10'd1;
  end

  // state, position, direction and strobe latches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= PARKED;
      r_x       <= PARK_OFS;
      r_y       <= PARK_Y;
      r_dr      <= 1'b1;
      r_dd      <= 1'b0;
      r_in_play <= 1'b0;
      r_respawn <= 1'b0;
      r_bfx     <= 1'b0;
      r_bfy     <= 1'b0;
    end else begin
      r_respawn <= 1'b0;
      unique case (r_state)
        PARKED: begin
          r_x   <= w_park_x;
          r_y   <= PARK_Y;
          r_bfx <= 1'b0;
          r_bfy <= 1'b0;
          if (bus.tick && bus.launch) begin
            r_state   <= MOVE;
            r_dr      <= 1'b1;
            r_dd      <= 1'b0;
            r_in_play <= 1'b1;
          end
        end
        MOVE: begin
          if (bus.tick) begin
            r_bfx <= 1'b0;
            r_bfy <= 1'b0;
            r_dr  <= w_dr;
            r_x   <= w_nx;
            if (w_miss) begin
              r_dd      <= 1'b1;
              r_y       <= w_y_inc;
              r_state   <= FALL;
              r_in_play <= 1'b0;
            end else begin
              r_dd <= w_dd;
              r_y  <= w_ny;
            end
          end else begin
            r_bfx <= w_flip_x;
            r_bfy <= w_flip_y;
          end
        end
        FALL: begin
          r_bfx <= 1'b0;
          r_bfy <= 1'b0;
          if (bus.tick) begin
            r_dr <= w_dr;
            r_x  <= w_nx;
            r_y  <= w_y_inc;
            if (w_y_inc >= FLOOR_Y) begin
              r_state   <= PARKED;
              r_respawn <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= PARKED;
          r_in_play <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_mover.sv
// Scoreboard bench for ball_mover: per-cycle model
// expectations queued at drive time, popped after the edge.
module tb_ball_mover;

  typedef struct {
    int x, y, dr, dd, ip, rs;
  } exp_t;

  logic clk;
  logic resetn;
  ball_mover_if bus ();

  ball_mover dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  exp_t q[$];

  int m_st, m_x, m_y, m_dr, m_dd, m_ip, m_rs;
  int m_bx, m_by;

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_x = 14; m_y = 220;
    m_dr = 1; m_dd = 0; m_ip = 0; m_rs = 0;
    m_bx = 0; m_by = 0;
  endtask

  task automatic model_step(input int tk, ln, bx, by);
    int px, lx, ly, fx, fy, line, over;
    px = bus.paddle_x;
    m_rs = 0;
    case (m_st)
      0: begin
        m_x = px + 14; m_y = 220;
        m_bx = 0; m_by = 0;
        if (tk && ln) begin
          m_st = 1; m_dr = 1; m_dd = 0;
        end
      end
      1: begin
        if (!tk) begin
          m_bx = m_bx | bx; m_by = m_by | by;
        end else begin
          lx = m_bx | bx; ly = m_by | by;
          m_bx = 0; m_by = 0;
          line = (m_dd && m_y + 4 == 224);
          over = (m_x + 4 > px) && (m_x < px + 32);
          fx = lx || (m_dr && m_x + 4 >= 320)
                  || (!m_dr && m_x == 0);
          fy = ly || (!m_dd && m_y == 0)
                  || (line && over);
          if (line && !over) begin
            m_st = 2; m_y = m_y + 1;
          end else begin
            if (fy) m_dd = 1 - m_dd;
            if (m_dd) m_y = m_y + 1;
            else if (m_y > 0) m_y = m_y - 1;
          end
          if (fx) m_dr = 1 - m_dr;
          if (m_dr) m_x = (m_x >= 316) ? 316 : m_x + 1;
          else if (m_x > 0) m_x = m_x - 1;
        end
      end
      default: begin
        m_bx = 0; m_by = 0;
        if (tk) begin
          fx = (m_dr && m_x + 4 >= 320)
            || (!m_dr && m_x == 0);
          if (fx) m_dr = 1 - m_dr;
          if (m_dr) m_x = (m_x >= 316) ? 316 : m_x + 1;
          else if (m_x > 0) m_x = m_x - 1;
          m_y = m_y + 1;
          if (m_y >= 236) begin
            m_st = 0; m_rs = 1;
          end
        end
      end
    endcase
    m_ip = (m_st == 1) ? 1 : 0;
  endtask

  task automatic cyc(input int tk, ln, bx, by);
    exp_t e;
    bus.tick = tk[0];
    bus.launch = ln[0];
    bus.brick_flip_x = bx[0];
    bus.brick_flip_y = by[0];
    model_step(tk, ln, bx, by);
    e = '{m_x, m_y, m_dr, m_dd, m_ip, m_rs};
    q.push_back(e);
    @(posedge clk); #1;
    bus.tick = 1'b0;
    bus.launch = 1'b0;
    bus.brick_flip_x = 1'b0;
    bus.brick_flip_y = 1'b0;
    e = q.pop_front();
    chk("sb_x", bus.ball_x, e.x);
    chk("sb_y", bus.ball_y, e.y);
    chk("sb_dr", bus.dir_right, e.dr);
    chk("sb_dd", bus.dir_down, e.dd);
    chk("sb_inplay", bus.in_play, e.ip);
    chk("sb_respawn", bus.respawn, e.rs);
  endtask

  task automatic step_tick(input int bx, by);
    cyc(1, 0, bx, by);
    cyc(0, 0, 0, 0);
  endtask

  task automatic run_to_line(input string tag);
    for (int n = 0; n < 700 && !(m_y == 220 && m_dd == 1); n++)
      step_tick(0, 0);
    chk(tag, (m_y == 220 && m_dd == 1) ? 1 : 0, 1);
  endtask

  task automatic force_miss();
    bus.paddle_x = 10'((m_x < 160) ? m_x + 100 : m_x - 100);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("miss_inplay", bus.in_play, 0);
    chk("miss_y", bus.ball_y, 221);
    chk("miss_dd", bus.dir_down, 1);
  endtask

  initial begin
    resetn = 1'b1;
    bus.tick = 1'b0;
    bus.launch = 1'b0;
    bus.paddle_x = 10'd100;
    bus.brick_flip_x = 1'b0;
    bus.brick_flip_y = 1'b0;
    model_reset();
    #1 resetn = 1'b0;
    #2;
    chk("rst_x", bus.ball_x, 14);
    chk("rst_y", bus.ball_y, 220);
    chk("rst_dr", bus.dir_right, 1);
    chk("rst_dd", bus.dir_down, 0);
    chk("rst_inplay", bus.in_play, 0);
    chk("rst_respawn", bus.respawn, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("park_x100", bus.ball_x, 114);
    chk("park_y", bus.ball_y, 220);
    bus.paddle_x = 10'd50;
    cyc(0, 0, 0, 0);
    chk("park_x50", bus.ball_x, 64);
    cyc(0, 1, 0, 0);
    chk("launch_no_tick", bus.in_play, 0);

    bus.paddle_x = 10'd100;
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("launch_inplay", bus.in_play, 1);
    chk("launch_x", bus.ball_x, 114);
    cyc(0, 1, 0, 0);
    step_tick(0, 0);
    chk("first_x", bus.ball_x, 115);
    chk("first_y", bus.ball_y, 219);
    chk("first_dr", bus.dir_right, 1);
    chk("first_dd", bus.dir_down, 0);

    for (int n = 0; n < 400 && m_x != 316; n++)
      step_tick(0, 0);
    chk("reach_rwall", m_x, 316);
    cyc(0, 0, 1, 0);
    step_tick(0, 0);
    chk("rwall_dr", bus.dir_right, 0);
    chk("rwall_x", bus.ball_x, 315);

    for (int n = 0; n < 400 && !(m_y == 0 && m_dd == 0); n++)
      step_tick(0, 0);
    chk("reach_top", m_y, 0);
    step_tick(0, 0);
    chk("top_dd", bus.dir_down, 1);
    chk("top_y", bus.ball_y, 1);

    step_tick(0, 1);
    chk("bfy_same_dd", bus.dir_down, 0);
    chk("bfy_same_y", bus.ball_y, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    step_tick(0, 0);
    chk("bfy_latch_dd", bus.dir_down, 1);

    run_to_line("reach_line1");
    bus.paddle_x = 10'((m_x >= 10) ? m_x - 10 : 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("paddle_dd", bus.dir_down, 0);
    chk("paddle_y", bus.ball_y, 219);
    chk("paddle_inplay", bus.in_play, 1);
    cyc(0, 0, 0, 0);

    run_to_line("reach_line2");
    force_miss();
    cyc(0, 0, 1, 1);
    for (int n = 0; n < 14; n++)
      step_tick(1, 1);
    cyc(1, 0, 0, 0);
    chk("fall_y", bus.ball_y, 236);
    chk("fall_respawn", bus.respawn, 1);
    cyc(0, 0, 0, 0);
    chk("respawn_clr", bus.respawn, 0);
    chk("respawn_y", bus.ball_y, 220);
    chk("respawn_inplay", bus.in_play, 0);

    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    run_to_line("reach_line3");
    force_miss();
    step_tick(0, 0);
    step_tick(0, 0);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    chk("midfall_x", bus.ball_x, 14);
    chk("midfall_y", bus.ball_y, 220);
    chk("midfall_inplay", bus.in_play, 0);
    chk("midfall_dr", bus.dir_right, 1);
    chk("midfall_dd", bus.dir_down, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    cyc(0, 0, 0, 0);
    step_tick(0, 0);
    chk("post_rst_inplay", bus.in_play, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ball_mover.md
Name: ball_mover

Overview:
- Generates the ball position consumed by the play-field checkers, including the loss detector and the collision logic.
- Parks the ball on the paddle, launches it, advances it one pixel per axis per frame tick, and bounces it off the walls, the paddle and bricks.
- When the ball misses the paddle, it is allowed to fall below the paddle line, which is the crossing the loss detector counts. The ball is then re-parked on the paddle.

Parameters:
- SCREEN_W, 320, play-field width in pixels.
- SCREEN_H, 240, play-field height in pixels.
- PLATY, 224, paddle top row; the same value as the shared `PLATY macro.
- PADDLE_W, 32, paddle width in pixels.
- BALL_SIZE, 4, ball edge length in pixels. ball_x/ball_y give the top-left corner.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle frame-rate move strobe.
- launch  in  1  level; starts play from PARKED.
- paddle_x  in  10  paddle left edge.
- brick_flip_x  in  1  one-cycle strobe from collision logic: negate horizontal direction.
- brick_flip_y  in  1  one-cycle strobe from collision logic: negate vertical direction.
- ball_x  out  10  ball left edge.
- ball_y  out  10  ball top edge.
- dir_right  out  1  1 = moving +x.
- dir_down  out  1  1 = moving +y.
- in_play  out  1  1 while in state MOVE.
- respawn  out  1  one-cycle pulse when the ball is re-parked after a miss.

Behaviour:
- States:
  - PARKED (reset state).
  - MOVE.
  - FALL.
- Reset (asynchronous, resetn=0):
  - State = PARKED.
  - ball_x = paddle-centred value: PADDLE_W/2 - BALL_SIZE/2, computed with paddle_x treated as 0.
  - ball_y = PLATY - BALL_SIZE.
  - dir_right=1, dir_down=0.
  - in_play=0, respawn=0.
- PARKED:
  - Every clock: ball_x <= paddle_x + PADDLE_W/2 - BALL_SIZE/2, and ball_y <= PLATY - BALL_SIZE.
  - If launch=1 on a tick cycle: go to MOVE with dir_right=1, dir_down=0. Position does not change on that tick.
  - launch outside a tick is ignored.
- MOVE, evaluated only on tick. All direction decisions use the pre-move position.
  - Horizontal flip (fx) asserts when any of these holds:
    - brick_flip_x is seen on this tick, or is latched since the last tick;
    - dir_right=1 and ball_x + BALL_SIZE >= SCREEN_W;
    - dir_right=0 and ball_x == 0.
  - Vertical flip (fy) asserts when any of these holds:
    - brick_flip_y is latched;
    - dir_down=0 and ball_y == 0;
    - paddle hit: dir_down=1, ball_y + BALL_SIZE == PLATY, and ball_x + BALL_SIZE > paddle_x and ball_x < paddle_x + PADDLE_W.
  - Multiple simultaneous causes on one axis flip that axis exactly once (OR, not XOR).
  - The new direction is applied first, then the ball moves one pixel in that direction on each axis during the same tick. Latency: position and direction outputs are valid the cycle after the tick.
  - Miss: if dir_down=1 and ball_y + BALL_SIZE == PLATY with no paddle overlap, the ball continues downward and the state goes to FALL.
- brick_flip latches:
  - brick_flip_x and brick_flip_y strobes are held in sticky flags until the next tick, then cleared.
  - They are ignored outside MOVE.
  - A strobe on the same cycle as the tick is consumed by that tick.
- FALL:
  - On each tick: ball_y += 1 and ball_x continues, with wall bounces still active. Brick and paddle flips are ignored.
  - When ball_y reaches SCREEN_H - BALL_SIZE: go to PARKED and pulse respawn for one cycle.
- in_play = (state==MOVE), registered.
- Arithmetic:
  - All comparisons use 11-bit sums so there is no wrap.
  - ball_x is clamped to [0, SCREEN_W - BALL_SIZE]; ball_y never underflows.
- launch held high continuously: this is allowed; it only matters in PARKED.

Decomposition:
- Shared package/macros header holds:
  - PLATY (existing), SCREEN_W, SCREEN_H, BALL_SIZE, PADDLE_W;
  - the state encoding (PARKED=2'd0, MOVE=2'd1, FALL=2'd2).
- Natural sub-module: ball_bounce_logic. It is combinational and takes position, directions, paddle_x and the latched flips, and returns fx, fy and miss. The FSM and registers stay in ball_mover.

Test Plan:
- Reset, then paddle_x=100 with no launch → ball_x=114, ball_y=220, in_play=0. Change paddle_x to 50 → ball_x=64 next cycle.
- launch=1 with tick → in_play=1. After the next tick, ball at (115,219), moving right and up.
- Ball at x=316 moving right, tick → dir_right=0 and ball_x=315. Ball at y=0 moving up, tick → dir_down=1 and ball_y=1.
- Ball at y=220 moving down, ball_x=110, paddle_x=100, tick → dir_down=0 and ball_y=219. Same with paddle_x=200 → state FALL and ball_y=221.
- brick_flip_x strobe while the ball sits at the right wall, then tick → exactly one flip: dir_right=0.
- FALL from y=221 → after 15 ticks, ball_y=236, then respawn pulses for one cycle. Ball is parked at y=220. Assert resetn=0 mid-FALL → immediate PARKED.
